// File: rtl/hwjsoc_oci_trace_pkg.sv
// Shared types and constants for the OCI trace capture block.
package hwjsoc_oci_trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int TS_W      = 16;
    localparam int OVF_CNT_W = 16;

    // Buffered entries are only presented to the consumer once capture has started.
    function automatic logic state_readable(input state_t s);
        return (s == ST_CAPTURE) || (s == ST_DRAIN) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/hwjsoc_oci_trace_ram.sv
// Trace buffer storage: one synchronous write port, one asynchronous read port.
module hwjsoc_oci_trace_ram #(
    parameter int DEPTH  = 16,
    parameter int WORD_W = 30,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hwjsoc_cpu_oci_trace_capture.sv
// OCI trace capture: records dct_buffer on each dct_count change into a show-ahead FIFO.
// Optional timestamp tagging enabled by macro HWJSOC_OCI_TRACE_TIMESTAMP_EN.
module hwjsoc_cpu_oci_trace_capture
    import hwjsoc_oci_trace_pkg::*;
#(
    parameter int DCT_W     = 30,
    parameter int CNT_W     = 4,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 0,
`ifdef HWJSOC_OCI_TRACE_TIMESTAMP_EN
    localparam int WORD_W   = DCT_W + TS_W,
`else
    localparam int WORD_W   = DCT_W,
`endif
    localparam int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DCT_W-1:0]     dct_buffer,
    input  logic [CNT_W-1:0]     dct_count,
    input  logic                 test_ending,
    input  logic                 test_has_ended,
    input  logic                 rd_ready,
    output logic                 rd_valid,
    output logic [WORD_W-1:0]    rd_data,
    output logic [LVL_W-1:0]     level,
    output logic                 overflow,
    output logic [OVF_CNT_W-1:0] overflow_count,
    output logic [2:0]           state,
    output logic                 done
);

    localparam int AW = $clog2(DEPTH);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_prev_count;
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic                   r_overflow;
    logic [OVF_CNT_W-1:0]   r_ovf_cnt;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_evict;
    logic                   w_store;
    logic [WORD_W-1:0]      w_wdata;

`ifdef HWJSOC_OCI_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]        r_ts;

    // Zeroed on the IDLE->ARMED edge so the first ARMED cycle reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts <= '0;
        end else if (r_state == ST_IDLE && enable) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    assign w_wdata = {r_ts, dct_buffer};
`else
    assign w_wdata = dct_buffer;
`endif

    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_push  = enable && (r_state == ST_CAPTURE) && (dct_count != '0) &&
                     (dct_count != r_prev_count);
    assign w_pop   = rd_valid && rd_ready;
    // A same-cycle pop frees the slot, so only an unpaired push into a full buffer loses data.
    assign w_drop  = w_push && w_full && !w_pop && (WRAP_MODE == 0);
    assign w_evict = w_push && w_full && !w_pop && (WRAP_MODE != 0);
    assign w_store = w_push && !w_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_nxt = ST_ARMED;
                ST_ARMED:   if (dct_count == '0) w_state_nxt = ST_CAPTURE;
                ST_CAPTURE: if (test_ending || test_has_ended) w_state_nxt = ST_DRAIN;
                ST_DRAIN:   if (r_level == '0 && test_has_ended) w_state_nxt = ST_DONE;
                ST_DONE:    w_state_nxt = ST_DONE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_valid = (r_level != '0) && state_readable(r_state);
        done     = (r_state == ST_DONE);
        state    = r_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_count <= '0;
        end else begin
            r_prev_count <= dct_count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop || w_evict) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_store && !w_pop && !w_evict) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_store) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_ovf_cnt  <= '0;
        end else if (w_drop || w_evict) begin
            r_overflow <= 1'b1;
            if (r_ovf_cnt != '1) begin
                r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
            end
        end
    end

    hwjsoc_oci_trace_ram #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_store),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (rd_data)
    );

    assign level          = r_level;
    assign overflow       = r_overflow;
    assign overflow_count = r_ovf_cnt;

endmodule
